// File: rtl/inst_loader.sv
// -----------------------------------------------------------------------------
// inst_loader
// Upstream feeder of the instruction-fetch stage. Takes a program arriving as
// a byte stream from the UART receiver and writes it byte-by-byte into
// instruction memory. When a complete word equal to HALT_WORD arrives, it
// releases the PC so fetch starts at address 0. If memory fills before HALT
// arrives, it flags overflow.
//
// Ports:
//   i_clock             system clock, rising edge
//   i_reset             asynchronous active-low reset
//   i_start             one-cycle pulse: begin (or restart) a load
//   i_rx_data           received byte
//   i_rx_valid          one-cycle pulse: i_rx_data valid this cycle
//   o_write_enable      instruction-memory write strobe
//   o_write_data        byte to write
//   o_write_addr        byte address of the write
//   o_instru_mem_enable instruction-memory enable (always on)
//   o_pc_reset          high = hold PC at 0
//   o_pc_enable         high = PC may advance
//   o_load_done         high while in DONE
//   o_overflow          high while in ERROR
//   o_word_count        complete words written in this load, HALT included
// -----------------------------------------------------------------------------
module inst_loader #(
  parameter int          INSTMEM_SIZE = 8,
  parameter int          MEM_SIZE     = 8,
  parameter logic [31:0] HALT_WORD    = 32'hFFFFFFFF
) (
  input  logic                    i_clock,
  input  logic                    i_reset,
  input  logic                    i_start,
  input  logic [MEM_SIZE-1:0]     i_rx_data,
  input  logic                    i_rx_valid,
  output logic                    o_write_enable,
  output logic [MEM_SIZE-1:0]     o_write_data,
  output logic [INSTMEM_SIZE-1:0] o_write_addr,
  output logic                    o_instru_mem_enable,
  output logic                    o_pc_reset,
  output logic                    o_pc_enable,
  output logic                    o_load_done,
  output logic                    o_overflow,
  output logic [INSTMEM_SIZE-2:0] o_word_count
);

  typedef enum logic [1:0] {IDLE, LOAD, DONE, ERROR} state_t;

  localparam logic [INSTMEM_SIZE-1:0] ADDR_MAX = '1;
  localparam logic [INSTMEM_SIZE-1:0] ADDR_ONE = {{(INSTMEM_SIZE-1){1'b0}}, 1'b1};
  localparam logic [INSTMEM_SIZE-2:0] WC_ONE   = {{(INSTMEM_SIZE-2){1'b0}}, 1'b1};

  state_t                    state_q;
  logic [INSTMEM_SIZE-1:0]   addr_q;
  logic [1:0]                byte_idx_q;
  // Only the three previously received bytes need to be kept; the current
  // byte completes the word combinationally.
  logic [3*MEM_SIZE-1:0]     shift_q;

  logic [4*MEM_SIZE-1:0]     word_d;
  logic                      word_done;
  logic                      halt_hit;

  assign word_d    = {shift_q, i_rx_data};
  assign word_done = (byte_idx_q == 2'd3);
  assign halt_hit  = word_done && (word_d == HALT_WORD);

  assign o_instru_mem_enable = 1'b1;

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state_q        <= IDLE;
      addr_q         <= '0;
      byte_idx_q     <= 2'd0;
      shift_q        <= '0;
      o_word_count   <= '0;
      o_write_enable <= 1'b0;
      o_write_data   <= '0;
      o_write_addr   <= '0;
      o_pc_reset     <= 1'b1;
      o_pc_enable    <= 1'b0;
      o_load_done    <= 1'b0;
      o_overflow     <= 1'b0;
    end else begin
      // The strobe is a single-cycle pulse following an accepted byte.
      o_write_enable <= 1'b0;

      if (i_start) begin
        // Start wins over any byte arriving in the same cycle.
        state_q      <= LOAD;
        addr_q       <= '0;
        byte_idx_q   <= 2'd0;
        shift_q      <= '0;
        o_word_count <= '0;
        o_pc_reset   <= 1'b1;
        o_pc_enable  <= 1'b0;
        o_load_done  <= 1'b0;
        o_overflow   <= 1'b0;
      end else begin
        case (state_q)
          LOAD: begin
            if (i_rx_valid) begin
              o_write_enable <= 1'b1;
              o_write_data   <= i_rx_data;
              o_write_addr   <= addr_q;
              shift_q        <= word_d[3*MEM_SIZE-1:0];
              byte_idx_q     <= byte_idx_q + 2'd1;
              if (word_done) begin
                o_word_count <= o_word_count + WC_ONE;
              end
              if (halt_hit) begin
                state_q     <= DONE;
                o_load_done <= 1'b1;
                o_pc_reset  <= 1'b0;
                o_pc_enable <= 1'b1;
              end else if (addr_q == ADDR_MAX) begin
                // Last location written without HALT: stop rather than wrap.
                state_q    <= ERROR;
                o_overflow <= 1'b1;
              end else begin
                addr_q <= addr_q + ADDR_ONE;
              end
            end
          end
          default: begin
            // IDLE, DONE and ERROR ignore incoming bytes and hold outputs.
          end
        endcase
      end
    end
  end

endmodule

// File: doc/inst_loader.md
Name: inst_loader

Overview:
- Upstream feeder of the instruction-fetch stage.
- Receives a program as a byte stream from the UART receiver and writes it byte-by-byte into instruction memory.
- Detects the HALT word, then releases the PC so fetch starts at address 0.
- Flags overflow if memory fills before HALT arrives.

Parameters:
- INSTMEM_SIZE, 8, instruction-memory byte-address width (capacity 2^INSTMEM_SIZE bytes).
- MEM_SIZE, 8, data width of one memory write (one byte).
- HALT_WORD, 32'hFFFFFFFF, 32-bit word that terminates a program load.

Ports:
- i_clock  in  1  system clock; all state updates on rising edge.
- i_reset  in  1  asynchronous, active-low reset.
- i_start  in  1  one-cycle pulse: begin (or restart) a load.
- i_rx_data  in  MEM_SIZE  received byte.
- i_rx_valid  in  1  one-cycle pulse: i_rx_data valid this cycle.
- o_write_enable  out  1  instruction-memory write strobe.
- o_write_data  out  MEM_SIZE  byte to write.
- o_write_addr  out  INSTMEM_SIZE  byte address of write.
- o_instru_mem_enable  out  1  instruction-memory enable.
- o_pc_reset  out  1  high = hold PC at 0.
- o_pc_enable  out  1  high = PC may advance.
- o_load_done  out  1  high while in DONE.
- o_overflow  out  1  high while in ERROR.
- o_word_count  out  INSTMEM_SIZE-1  complete words written in the current load, including HALT.

Behaviour:
- Reset (i_reset low, asynchronous):
  - state = IDLE; address counter, byte index, shift register and o_word_count = 0.
  - o_write_enable = 0, o_write_data = 0, o_write_addr = 0.
  - o_instru_mem_enable = 1, o_pc_reset = 1, o_pc_enable = 0, o_load_done = 0, o_overflow = 0.
- States: IDLE, LOAD, DONE, ERROR. All outputs registered.
- IDLE:
  - PC held (o_pc_reset = 1, o_pc_enable = 0); i_rx_valid ignored.
  - i_start -> LOAD, with address, byte index, shift register and word count cleared.
- LOAD, per byte:
  - i_rx_valid in cycle n -> o_write_enable = 1 in cycle n+1 only, o_write_data = byte, o_write_addr = current address.
  - Address then increments by 1.
  - Byte index counts 0..3 within the word; shift register = {shift[23:0], byte}, so the first-received byte becomes the MSB.
- LOAD, word completion (byte index 3):
  - o_word_count increments.
  - If the completed word == HALT_WORD -> DONE in the same cycle as the write (o_load_done = 1 in cycle n+1).
  - The HALT-check occurs only on word boundaries; a HALT pattern straddling words is not detected.
- LOAD, overflow:
  - If the written address is 2^INSTMEM_SIZE-1 and the completed word is not HALT_WORD -> ERROR.
  - The address counter never wraps to rewrite address 0.
- LOAD, restart: i_start while in LOAD restarts the load (counters cleared, stay in LOAD). A simultaneous i_rx_valid byte is dropped; i_start has priority.
- DONE:
  - o_pc_reset = 0, o_pc_enable = 1, o_load_done = 1.
  - i_rx_valid ignored; i_start -> LOAD with PC reasserted into reset (o_pc_reset = 1, o_pc_enable = 0) the next cycle.
- ERROR:
  - o_overflow = 1, PC held in reset; i_rx_valid ignored.
  - i_start -> LOAD with o_overflow cleared.
- Write strobe timing:
  - o_write_enable never asserts outside the cycle after an accepted byte.
  - At most one write per cycle; back-to-back i_rx_valid on consecutive cycles yields consecutive writes.
- Reset mid-load: an asynchronous return to the reset values; no partial write is completed.

Test Plan:
- Reset then i_start, then bytes 20,08,00,05 / FF,FF,FF,FF:
  - Writes at addr 0..7 with data 0x20,0x08,0x00,0x05,0xFF,0xFF,0xFF,0xFF.
  - o_word_count = 2; o_load_done = 1 and o_pc_enable = 1 in the cycle of the addr-7 write.
- Bytes 00,FF,FF,FF,FF,00,00,00 (unaligned HALT pattern):
  - No DONE; all 8 bytes written; o_word_count = 2; state remains LOAD.
- INSTMEM_SIZE=4, 16 bytes of 0x11:
  - Writes to addr 0..15.
  - o_overflow = 1 after the 16th byte; o_pc_reset stays 1; the 17th byte produces no write.
- i_rx_valid with 0xAB in IDLE and DONE -> o_write_enable stays 0.
- i_start and i_rx_valid in the same cycle mid-load (after 3 bytes):
  - Byte dropped; the next byte is written at addr 0; o_word_count = 0.
- i_reset low asynchronously mid-load (between clock edges):
  - All outputs go to reset values immediately.
  - A subsequent i_start plus a 4-byte HALT word gives DONE with o_word_count = 1.
